// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator pipeline:
// format codes and the base RV32/RV64 opcode map.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_I_SHAMT = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_U       = 3'd5,
        FMT_J       = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classification and immediate extraction
// for one RV32/RV64 instruction word.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opc;
    logic [2:0] f3;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];

    assign imm_i = $signed(instr_i[31:20]);
    assign imm_s = $signed({instr_i[31:25], instr_i[11:7]});
    assign imm_b = $signed({instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0});
    assign imm_u = $signed({instr_i[31:12], 12'b0});
    assign imm_j = $signed({instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0});

    always_comb begin
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        unique case (1'b1)
            (opc == OPC_LOAD),
            (opc == OPC_JALR):
                fmt_o = FMT_I;
            (opc == OPC_OP_IMM),
            (RV64 && (opc == OPC_OP_IMM32)):
                fmt_o = is_shift(f3) ? FMT_I_SHAMT : FMT_I;
            (opc == OPC_STORE):
                fmt_o = FMT_S;
            (opc == OPC_BRANCH):
                fmt_o = FMT_B;
            (opc == OPC_LUI),
            (opc == OPC_AUIPC):
                fmt_o = FMT_U;
            (opc == OPC_JAL):
                fmt_o = FMT_J;
            (opc == OPC_OP),
            (RV64 && (opc == OPC_OP32)):
                fmt_o = FMT_NONE;
            default:
                illegal_o = 1'b1;
        endcase
    end

    // Only the 64-bit OP-IMM shifts use the sixth shamt bit
    always_comb begin
        imm_o = '0;
        unique case (fmt_o)
            FMT_I: imm_o = XLEN'(imm_i);
            FMT_S: imm_o = XLEN'(imm_s);
            FMT_B: imm_o = XLEN'(imm_b);
            FMT_U: imm_o = XLEN'(imm_u);
            FMT_J: imm_o = XLEN'(imm_j);
            FMT_I_SHAMT: begin
                if (RV64 && (opc == OPC_OP_IMM))
                    imm_o = XLEN'(instr_i[25:20]);
                else
                    imm_o = XLEN'(instr_i[24:20]);
            end
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode at input, 2-entry result FIFO,
// valid/ready on both sides and a saturating illegal-opcode counter.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      ill_cnt
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;

    imm_decode #(
        .XLEN(XLEN)
    ) u_dec (
        .instr_i  (in_instr),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_ill)
    );

    logic [XLEN-1:0]  imm_q [2];
    fmt_e             fmt_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       ill_q;

    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [15:0] ill_cnt_q, ill_cnt_d;

    logic push;
    logic pop;

    // in_ready depends only on state and rst, never on out_ready
    assign in_ready  = (cnt_q != 2'd2) && !rst;
    assign out_valid = (cnt_q != 2'd0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        cnt_d     = cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 2'd1;
        else if (pop && !push)
            cnt_d = cnt_q - 2'd1;
        if (push && dec_ill && (ill_cnt_q != 16'hFFFF))
            ill_cnt_d = ill_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            ill_cnt_q <= 16'd0;
            ill_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_NONE;
                tag_q[i] <= '0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            ill_cnt_q <= ill_cnt_d;
            if (push) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                tag_q[wr_ptr_q] <= in_tag;
                ill_q[wr_ptr_q] <= dec_ill;
            end
        end
    end

    assign out_imm     = imm_q[rd_ptr_q];
    assign out_fmt     = fmt_q[rd_ptr_q];
    assign out_tag     = tag_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];
    assign ill_cnt     = ill_cnt_q;

endmodule
